// File: rtl/rf_user_loader_pkg.sv
// -----------------------------------------------------------------------------
// rf_user_loader_pkg
// Shared definitions for the register-file burst loader:
//   RF_ADDR_W / RF_DATA_W / RF_DEPTH - register file geometry
//   RF_CNT_W                        - width of the requested byte count
//   state_t                         - loader FSM state encoding
//   clamp_count()                   - limits a requested count to RF_DEPTH
// -----------------------------------------------------------------------------
package rf_user_loader_pkg;

    localparam int RF_ADDR_W = 3;
    localparam int RF_DATA_W = 8;
    localparam int RF_DEPTH  = 8;
    localparam int RF_CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A burst can never cover more than the whole register file.
    function automatic logic [RF_CNT_W-1:0] clamp_count(input logic [RF_CNT_W-1:0] cnt);
        if (cnt > RF_CNT_W'(RF_DEPTH)) begin
            return RF_CNT_W'(RF_DEPTH);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rf_wr_mux.sv
// -----------------------------------------------------------------------------
// rf_wr_mux
// Registered two-source arbiter for the register-file write port.
// The pipeline writeback always wins; the loader stream only asks for the
// port when the pipeline is idle (the loader deasserts in_ready otherwise),
// so nothing is ever dropped here.
// With no request the address/data registers hold and the strobe drops.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   wb_write_i/_addr_i/_data_i   pipeline writeback request
//   st_write_i/_addr_i/_data_i   loader stream write request
//   write_o/addr_o/data_o        registered write-port drive
// -----------------------------------------------------------------------------
module rf_wr_mux
    import rf_user_loader_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_write_i,
    input  logic [RF_ADDR_W-1:0] wb_addr_i,
    input  logic [RF_DATA_W-1:0] wb_data_i,
    input  logic                 st_write_i,
    input  logic [RF_ADDR_W-1:0] st_addr_i,
    input  logic [RF_DATA_W-1:0] st_data_i,
    output logic                 write_o,
    output logic [RF_ADDR_W-1:0] addr_o,
    output logic [RF_DATA_W-1:0] data_o
);

    logic                 write_q, write_d;
    logic [RF_ADDR_W-1:0] addr_q,  addr_d;
    logic [RF_DATA_W-1:0] data_q,  data_d;

    always_comb begin
        write_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (wb_write_i) begin
            write_d = 1'b1;
            addr_d  = wb_addr_i;
            data_d  = wb_data_i;
        end else if (st_write_i) begin
            write_d = 1'b1;
            addr_d  = st_addr_i;
            data_d  = st_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign write_o = write_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/rf_user_loader.sv
// -----------------------------------------------------------------------------
// rf_user_loader
// Burst loader that streams host bytes into consecutive register-file
// entries (address wraps mod RF_DEPTH) while sharing the write port with the
// pipeline writeback, which always has priority.
//
// Handshake: a host byte moves when in_valid && in_ready are both high at a
// rising clk edge; in_ready is high only in LOAD with no writeback and no
// abort in the same cycle, and in_valid may stay low indefinitely.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, base_addr, count     burst request (count > 8 clamps to 8)
//   abort                       cancel an active burst (no done pulse)
//   in_valid, in_data, in_ready host byte stream
//   wb_write, wb_addr, wb_data  pipeline writeback request
//   write, wr_addr, wr_data     registered register-file write port
//   busy, done, stall_req       status (stall_req == busy)
//   checksum                    XOR of bytes of the current/last burst
//   dbg_state                   current FSM state (state_t encoding)
//
// Build option: define RF_LOADER_CHKSUM_EN to implement the checksum
// register; otherwise checksum is tied to zero.
// -----------------------------------------------------------------------------
module rf_user_loader
    import rf_user_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [RF_ADDR_W-1:0] base_addr,
    input  logic [RF_CNT_W-1:0]  count,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [RF_DATA_W-1:0] in_data,
    output logic                 in_ready,
    input  logic                 wb_write,
    input  logic [RF_ADDR_W-1:0] wb_addr,
    input  logic [RF_DATA_W-1:0] wb_data,
    output logic                 write,
    output logic [RF_ADDR_W-1:0] wr_addr,
    output logic [RF_DATA_W-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 stall_req,
    output logic [RF_DATA_W-1:0] checksum,
    output logic [1:0]           dbg_state
);

    state_t               state_q, state_d;
    logic [RF_ADDR_W-1:0] ptr_q,   ptr_d;
    logic [RF_CNT_W-1:0]  rem_q,   rem_d;

    logic accept;
    logic start_load;

    assign in_ready   = (state_q == ST_LOAD) && !wb_write && !abort;
    assign accept     = in_valid && in_ready;
    assign start_load = (state_q == ST_IDLE) && start && (count != '0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d   = base_addr;
                        rem_d   = clamp_count(count);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    ptr_d = ptr_q + RF_ADDR_W'(1);
                    rem_d = rem_q - RF_CNT_W'(1);
                    if (rem_q == RF_CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
        end
    end

`ifdef RF_LOADER_CHKSUM_EN
    logic [RF_DATA_W-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_load) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q ^ in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    rf_wr_mux u_wr_mux (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb_write_i (wb_write),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .st_write_i (accept),
        .st_addr_i  (ptr_q),
        .st_data_i  (in_data),
        .write_o    (write),
        .addr_o     (wr_addr),
        .data_o     (wr_data)
    );

    assign busy      = (state_q != ST_IDLE);
    assign stall_req = busy;
    assign done      = (state_q == ST_DONE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_rf_user_loader.sv
module tb_rf_user_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] count;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wb_write;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       write;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       stall_req;
  logic [7:0] checksum;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard: {addr, data} of every write the port must show, in order.
  logic [10:0] exp_q[$];
  int          done_seen = 0;
  int          exp_done  = 0;
  logic [2:0]  exp_ptr   = 3'd0;
  logic [7:0]  exp_ck    = 8'h00;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rf_user_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .write     (write),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req),
    .checksum  (checksum),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {21'd0, wr_addr, wr_data}, 32'h0);
        end else begin
          check("write_addr_data", {21'd0, wr_addr, wr_data}, {21'd0, exp_q.pop_front()});
        end
      end
      if (done) done_seen++;
      check("stall_eq_busy", {31'd0, stall_req}, {31'd0, busy});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic [2:0] b, input logic [3:0] c);
    start = 1'b1; base_addr = b; count = c;
    if (c != 0) begin
      exp_ptr = b;
      exp_ck  = 8'h00;
    end
    exp_done++;
    step();
    start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_data = d;
    #1;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back({exp_ptr, d});
      exp_ptr = exp_ptr + 3'd1;
`ifdef RF_LOADER_CHKSUM_EN
      exp_ck = exp_ck ^ d;
`endif
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    step();
    step();
    check({name, "_queue_empty"}, exp_q.size(), 32'd0);
    check({name, "_done_count"}, done_seen, exp_done);
    check({name, "_idle"}, {30'd0, dbg_state}, 32'd0);
    check({name, "_checksum"}, {24'd0, checksum}, {24'd0, exp_ck});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; wb_write = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (3) step();
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_addr_data", {21'd0, wr_addr, wr_data}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("rst_checksum", {24'd0, checksum}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    step();

    // Burst r2..r4; 0x11^0x22^0x33 == 0x00.
    start_burst(3'd2, 4'd3);
    check("burst_busy", {31'd0, busy}, 32'd1);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    check("burst_done_pulse", {31'd0, done}, 32'd1);
    drain("burst");

    // Wrap 6,7,0,1.
    start_burst(3'd6, 4'd4);
    push_byte(8'hA0);
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    drain("wrap");

    // Unbalanced checksum (0x0F^0xF1 = 0xFE with the option enabled).
    start_burst(3'd3, 4'd2);
    push_byte(8'h0F);
    push_byte(8'hF1);
    drain("cksum");

    // Writeback conflict: r5=0x5A wins, stream byte follows.
    start_burst(3'd0, 4'd2);
    in_valid = 1'b1; in_data = 8'h77;
    wb_write = 1'b1; wb_addr = 3'd5; wb_data = 8'h5A;
    #1;
    check("conflict_in_ready", {31'd0, in_ready}, 32'd0);
    exp_q.push_back({3'd5, 8'h5A});
    step();
    wb_write = 1'b0;
    push_byte(8'h77);
    push_byte(8'h78);
    drain("conflict");

    // count = 0: straight to DONE, no write.
    start_burst(3'd4, 4'd0);
    check("cnt0_done", {31'd0, done}, 32'd1);
    drain("cnt0");

    // count = 12 clamps to 8 writes.
    start_burst(3'd5, 4'd12);
    for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
    in_valid = 1'b1; in_data = 8'hEE;
    #1;
    check("cnt12_no_ninth", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    drain("cnt12");

    // Abort after 2 of 5 bytes.
    start_burst(3'd1, 4'd5);
    exp_done--;
    push_byte(8'h41);
    push_byte(8'h42);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h43;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    drain("abort");

    // Reset mid-burst with competing activity.
    start_burst(3'd3, 4'd4);
    exp_done--;
    push_byte(8'h91);
    step();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h92;
    wb_write = 1'b1; wb_addr = 3'd7; wb_data = 8'hFF;
    step();
    check("midrst_write", {31'd0, write}, 32'd0);
    check("midrst_addr_data", {21'd0, wr_addr, wr_data}, 32'd0);
    check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    check("midrst_checksum", {24'd0, checksum}, 32'd0);
    exp_ck = 8'h00;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; wb_write = 1'b0;
    step();
    start_burst(3'd4, 4'd2);
    push_byte(8'h5C);
    push_byte(8'h3D);
    drain("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_user_loader.md
RF_USER_LOADER -- requirements
Module: rf_user_loader

Interface
REQ-001 SHALL provide clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide rst, input, 1, reset: synchronous and active-high.
REQ-003 SHALL provide start, input, 1, one-cycle request to begin a burst load.
REQ-004 SHALL provide base_addr, input, 3, first register to load; sampled with start.
REQ-005 SHALL provide count, input, 4, number of bytes to load; sampled with start; values above 8 clamp to 8.
REQ-006 SHALL provide abort, input, 1, cancels an active burst.
REQ-007 SHALL provide in_valid / in_data, inputs, 1 / 8, host byte stream.
REQ-008 SHALL provide in_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL provide wb_write / wb_addr / wb_data, inputs, 1 / 3 / 8, pipeline writeback request.
REQ-010 SHALL provide write / wr_addr / wr_data, outputs, 1 / 3 / 8, registered drive to the register-file write port.
REQ-011 SHALL provide busy, output, 1, burst in progress; done, output, 1, one-cycle completion pulse; stall_req, output, 1, equal to busy.
REQ-012 SHALL provide checksum, output, 8, running XOR of bytes accepted in the current or last burst.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-014 In IDLE, start=1 with count=0 SHALL go directly to DONE, with no writes.
REQ-015 In IDLE, start=1 with count>0 SHALL latch ptr=base_addr and remaining=min(count,8), clear checksum, and go to LOAD.
REQ-016 While not in IDLE, start SHALL be ignored.
REQ-017 In LOAD, in_ready SHALL be high exactly when wb_write=0 and abort=0; in all other states it SHALL be 0.
REQ-018 A byte SHALL be accepted when in_valid and in_ready are both 1.
REQ-019 On acceptance, the next cycle SHALL show write=1, wr_addr=ptr, wr_data=in_data (latency 1); ptr SHALL increment mod 8, remaining SHALL decrement, and checksum ^= in_data.
REQ-020 Accepting the byte that makes remaining 0 SHALL move the FSM to DONE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 A wb_write in any state SHALL produce, the next cycle, write=1, wr_addr=wb_addr, wr_data=wb_data; the pipeline always wins and is never dropped.
REQ-023 If neither an acceptance nor wb_write occurs, the next cycle SHALL show write=0 with wr_addr/wr_data holding their previous values.
REQ-024 abort in LOAD SHALL return the FSM to IDLE next cycle with no write from the stream that cycle; done SHALL NOT pulse, and writes already issued SHALL stand.
REQ-025 busy SHALL be 1 in LOAD and DONE.
REQ-026 An in_valid held low SHALL stall LOAD indefinitely, with no timeout.

Reset
REQ-027 rst=1 SHALL force the following next edge, in any state including mid-burst: FSM=IDLE, write=0, wr_addr=0, wr_data=0, done=0, busy=0, checksum=0, ptr=0, remaining=0.
REQ-028 rst SHALL take priority over start, abort, wb_write and the stream.

Configuration
REQ-029 With the macro RF_LOADER_CHKSUM_EN defined, checksum SHALL behave per REQ-012/019.
REQ-030 Without RF_LOADER_CHKSUM_EN, checksum SHALL be constant 0 and no checksum register SHALL exist.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, RF_ADDR_W=3, RF_DATA_W=8 and RF_DEPTH=8.
REQ-032 The block SHALL be one module; a write-port mux register sub-module, rf_wr_mux, is permitted but not required.

Verification
REQ-033 Burst: start, base=2, count=3, bytes 0x11,0x22,0x33 back-to-back -> writes r2=0x11, r3=0x22, r4=0x33 on consecutive cycles; done pulses once; checksum=0x00.
REQ-034 Wrap: base=6, count=4, bytes A0..A3 -> writes land at r6, r7, r0, r1.
REQ-035 Conflict: wb_write (r5=0x5A) asserted during LOAD with in_valid=1 -> in_ready=0 that cycle; r5=0x5A is written; the stream byte is written the following cycle with no loss.
REQ-036 Edge counts: count=0 -> done the next cycle with no write; count=12 -> exactly 8 writes.
REQ-037 Abort and reset: abort after 2 of 5 bytes -> 2 writes, no done, busy=0; rst mid-burst -> all outputs 0 the next cycle, and a new start works normally.
REQ-038 Macro off: the REQ-033 stimulus gives checksum=0 throughout.
